betting_round_ctrl: RTL and testbench

//  Runs one betting street (pre-flop, flop, turn or river) for 2..NUM_PLAYERS seats.

---
 rtl/betting_round_ctrl_if.sv | 40 ++++
 rtl/betting_round_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 tb/tb_betting_round_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/betting_round_ctrl_if.sv
// Street-level bus between the hand FSM (master) and the betting round controller (slave).
// Carries the street setup, the per-turn action handshake and the live table state.
interface betting_round_ctrl_if #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned STACK_W     = 11
);
    logic                           start;
    logic                           preflop;
    logic [2:0]                     button;
    logic [NUM_PLAYERS*STACK_W-1:0] stack_in;
    logic [STACK_W-1:0]             pot_in;
    logic [NUM_PLAYERS-1:0]         folded_in;
    logic                           act_valid;
    logic                           act_ready;
    logic [1:0]                     act_type;
    logic [STACK_W-1:0]             act_amount;
    logic [2:0]                     turn;
    logic [STACK_W-1:0]             call_amt;
    logic [STACK_W-1:0]             min_raise_to;
    logic [NUM_PLAYERS*STACK_W-1:0] stack_out;
    logic [STACK_W-1:0]             pot;
    logic [NUM_PLAYERS-1:0]         folded_out;
    logic                           illegal;
    logic                           round_done;
    logic                           hand_over;

    modport master (
        output start, preflop, button, stack_in, pot_in, folded_in,
        output act_valid, act_type, act_amount,
        input  act_ready, turn, call_amt, min_raise_to, stack_out, pot,
        input  folded_out, illegal, round_done, hand_over
    );

    modport slave (
        input  start, preflop, button, stack_in, pot_in, folded_in,
        input  act_valid, act_type, act_amount,
        output act_ready, turn, call_amt, min_raise_to, stack_out, pot,
        output folded_out, illegal, round_done, hand_over
    );
endinterface

// File: rtl/betting_round_ctrl.sv
// One betting street: blinds, turn sequencing, action validation and chip accounting.
// A single combinational pass computes the next table state; every output is a register.
module betting_round_ctrl #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned STACK_W     = 11,
    parameter int unsigned SB_SIZE     = 1,
    parameter int unsigned BB_SIZE     = 2
) (
    input logic                 clk,
    input logic                 reset,
    betting_round_ctrl_if.slave bus
);
    localparam int unsigned SEAT_W = 3;
    localparam int unsigned CNT_W  = 4;

    typedef logic [STACK_W-1:0]                     chips_t;
    typedef logic [SEAT_W-1:0]                      seat_t;
    typedef logic [CNT_W-1:0]                       cnt_t;
    typedef logic [NUM_PLAYERS-1:0]                 mask_t;
    typedef logic [NUM_PLAYERS-1:0][STACK_W-1:0]    table_t;

    localparam chips_t SB_CHIPS = chips_t'(SB_SIZE);
    localparam chips_t BB_CHIPS = chips_t'(BB_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POST_SB,
        S_POST_BB,
        S_WAIT_ACT,
        S_APPLY,
        S_DONE
    } state_t;

    function automatic seat_t next_seat(input seat_t s);
        if (32'(s) + 32'd1 >= NUM_PLAYERS) return '0;
        return s + seat_t'(1);
    endfunction

    function automatic logic seat_bit(input mask_t m, input seat_t s);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (seat_t'(i) == s) b = m[i];
        end
        return b;
    endfunction

    function automatic seat_t next_unfolded(input seat_t s, input mask_t folded);
        seat_t c;
        seat_t r;
        logic  found;
        c     = s;
        r     = next_seat(s);
        found = 1'b0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            c = next_seat(c);
            if (!found && !seat_bit(folded, c)) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic chips_t sat_add(input chips_t a, input chips_t b);
        logic [STACK_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STACK_W] ? '1 : s[STACK_W-1:0];
    endfunction

    function automatic chips_t min_chips(input chips_t a, input chips_t b);
        return (a < b) ? a : b;
    endfunction

    state_t r_state;
    table_t r_stack;
    table_t r_commit;
    chips_t r_pot;
    mask_t  r_folded;
    mask_t  r_allin;
    mask_t  r_acted;
    chips_t r_high_bet;
    chips_t r_last_raise;
    seat_t  r_turn;
    seat_t  r_button;
    seat_t  r_sb;
    logic [1:0] r_act_type;
    chips_t r_act_amt;
    logic   r_act_ready;
    logic   r_illegal;
    logic   r_round_done;
    logic   r_hand_over;
    chips_t r_call_amt;
    chips_t r_min_raise;

    state_t w_state;
    table_t w_stack;
    table_t w_commit;
    chips_t w_pot;
    mask_t  w_folded;
    mask_t  w_allin;
    mask_t  w_acted;
    chips_t w_high;
    chips_t w_last;
    seat_t  w_turn;
    seat_t  w_button;
    seat_t  w_sb;
    logic [1:0] w_act_type;
    chips_t w_act_amt;
    logic   w_illegal;
    logic   w_done;
    logic   w_hover;
    logic   w_post_en;
    seat_t  w_post_seat;
    chips_t w_post_amt;
    logic   w_eval;
    seat_t  w_from;
    logic   w_bad;
    chips_t w_d;
    chips_t w_pay;
    chips_t w_min_cur;
    cnt_t   w_unf_cnt;
    cnt_t   w_elig_cnt;
    mask_t  w_need;
    logic   w_all_ok;
    logic   w_one_match;
    logic   w_found;
    seat_t  w_seek;
    chips_t w_call;
    chips_t w_min_next;

    // Next-state and datapath: state-specific update, then shared blind post and turn search
    always_comb begin
        w_state     = r_state;
        w_stack     = r_stack;
        w_commit    = r_commit;
        w_pot       = r_pot;
        w_folded    = r_folded;
        w_allin     = r_allin;
        w_acted     = r_acted;
        w_high      = r_high_bet;
        w_last      = r_last_raise;
        w_turn      = r_turn;
        w_button    = r_button;
        w_sb        = r_sb;
        w_act_type  = r_act_type;
        w_act_amt   = r_act_amt;
        w_illegal   = 1'b0;
        w_done      = r_round_done;
        w_hover     = r_hand_over;
        w_post_en   = 1'b0;
        w_post_seat = r_turn;
        w_post_amt  = '0;
        w_eval      = 1'b0;
        w_from      = r_turn;
        w_bad       = 1'b0;
        w_d         = '0;
        w_pay       = '0;
        w_min_cur   = sat_add(r_high_bet, r_last_raise);
        w_unf_cnt   = '0;
        w_elig_cnt  = '0;
        w_need      = '0;
        w_all_ok    = 1'b1;
        w_one_match = 1'b0;
        w_found     = 1'b0;
        w_seek      = r_turn;
        w_call      = '0;
        w_min_next  = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_stack  = bus.stack_in;
                    w_commit = '0;
                    w_pot    = bus.pot_in;
                    w_folded = bus.folded_in;
                    w_allin  = '0;
                    w_acted  = '0;
                    w_high   = '0;
                    w_last   = BB_CHIPS;
                    w_button = bus.button;
                    w_done   = 1'b0;
                    w_hover  = 1'b0;
                    if (bus.preflop) begin
                        w_state = S_POST_SB;
                    end else begin
                        w_eval = 1'b1;
                        w_from = bus.button;
                    end
                end
            end
            S_POST_SB: begin
                w_post_seat = (NUM_PLAYERS == 2) ? r_button : next_unfolded(r_button, r_folded);
                w_post_amt  = SB_CHIPS;
                w_post_en   = 1'b1;
                w_sb        = w_post_seat;
                w_state     = S_POST_BB;
            end
            S_POST_BB: begin
                w_post_seat = next_unfolded(r_sb, r_folded);
                w_post_amt  = BB_CHIPS;
                w_post_en   = 1'b1;
                w_high      = BB_CHIPS;
                w_eval      = 1'b1;
                w_from      = w_post_seat;
            end
            S_WAIT_ACT: begin
                if (bus.act_valid && r_act_ready) begin
                    w_act_type = bus.act_type;
                    w_act_amt  = bus.act_amount;
                    w_state    = S_APPLY;
                end
            end
            S_APPLY: begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (seat_t'(i) == r_turn) begin
                        case (r_act_type)
                            2'b00: begin
                                w_pay = (r_high_bet > r_commit[i]) ?
                                        min_chips(r_high_bet - r_commit[i], r_stack[i]) : '0;
                                w_stack[i]  = r_stack[i] - w_pay;
                                w_commit[i] = r_commit[i] + w_pay;
                                w_pot       = sat_add(r_pot, w_pay);
                                w_acted[i]  = 1'b1;
                            end
                            2'b01: begin
                                w_d = r_act_amt - r_commit[i];
                                // Short all-in reopens the action but keeps the raise increment
                                if ((r_act_amt > r_high_bet) && (w_d <= r_stack[i]) &&
                                    ((r_act_amt >= w_min_cur) || (w_d == r_stack[i]))) begin
                                    if (r_act_amt >= w_min_cur) w_last = r_act_amt - r_high_bet;
                                    w_high      = r_act_amt;
                                    w_stack[i]  = r_stack[i] - w_d;
                                    w_commit[i] = r_act_amt;
                                    w_pot       = sat_add(r_pot, w_d);
                                    w_acted     = '0;
                                    w_acted[i]  = 1'b1;
                                end else begin
                                    w_bad = 1'b1;
                                end
                            end
                            2'b10:   w_folded[i] = 1'b1;
                            default: w_bad = 1'b1;
                        endcase
                        if (!w_bad && (w_stack[i] == '0)) w_allin[i] = 1'b1;
                    end
                end
                if (w_bad) begin
                    w_illegal = 1'b1;
                    w_state   = S_WAIT_ACT;
                end else begin
                    w_eval = 1'b1;
                    w_from = r_turn;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase

        if (w_post_en) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (seat_t'(i) == w_post_seat) begin
                    w_pay       = min_chips(w_post_amt, w_stack[i]);
                    w_stack[i]  = w_stack[i] - w_pay;
                    w_commit[i] = w_commit[i] + w_pay;
                    w_pot       = sat_add(w_pot, w_pay);
                    if (w_stack[i] == '0) w_allin[i] = 1'b1;
                end
            end
        end

        // Street end test, otherwise the next seat owing an action after w_from
        if (w_eval) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (!w_folded[i]) w_unf_cnt = w_unf_cnt + cnt_t'(1);
                if (!w_folded[i] && !w_allin[i]) begin
                    w_elig_cnt = w_elig_cnt + cnt_t'(1);
                    if (!w_acted[i] || (w_commit[i] != w_high)) begin
                        w_all_ok  = 1'b0;
                        w_need[i] = 1'b1;
                    end
                    if (w_commit[i] == w_high) w_one_match = 1'b1;
                end
            end
            if (w_unf_cnt <= cnt_t'(1)) begin
                w_state = S_DONE;
                w_done  = 1'b1;
                w_hover = 1'b1;
            end else if (w_all_ok || ((w_elig_cnt == cnt_t'(1)) && w_one_match)) begin
                w_state = S_DONE;
                w_done  = 1'b1;
                w_hover = 1'b0;
            end else begin
                w_state = S_WAIT_ACT;
                w_seek  = w_from;
                for (int k = 0; k < NUM_PLAYERS; k++) begin
                    w_seek = next_seat(w_seek);
                    if (!w_found && seat_bit(w_need, w_seek)) begin
                        w_turn  = w_seek;
                        w_found = 1'b1;
                    end
                end
            end
        end

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (seat_t'(i) == w_turn) begin
                w_call = (w_high > w_commit[i]) ? min_chips(w_high - w_commit[i], w_stack[i]) : '0;
            end
        end
        w_min_next = sat_add(w_high, w_last);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_stack      <= '0;
            r_commit     <= '0;
            r_pot        <= '0;
            r_folded     <= '0;
            r_allin      <= '0;
            r_acted      <= '0;
            r_high_bet   <= '0;
            r_last_raise <= '0;
            r_turn       <= '0;
            r_button     <= '0;
            r_sb         <= '0;
            r_act_type   <= '0;
            r_act_amt    <= '0;
            r_act_ready  <= 1'b0;
            r_illegal    <= 1'b0;
            r_round_done <= 1'b0;
            r_hand_over  <= 1'b0;
            r_call_amt   <= '0;
            r_min_raise  <= '0;
        end else begin
            r_state      <= w_state;
            r_stack      <= w_stack;
            r_commit     <= w_commit;
            r_pot        <= w_pot;
            r_folded     <= w_folded;
            r_allin      <= w_allin;
            r_acted      <= w_acted;
            r_high_bet   <= w_high;
            r_last_raise <= w_last;
            r_turn       <= w_turn;
            r_button     <= w_button;
            r_sb         <= w_sb;
            r_act_type   <= w_act_type;
            r_act_amt    <= w_act_amt;
            r_act_ready  <= (w_state == S_WAIT_ACT);
            r_illegal    <= w_illegal;
            r_round_done <= w_done;
            r_hand_over  <= w_hover;
            r_call_amt   <= w_call;
            r_min_raise  <= w_min_next;
        end
    end

    assign bus.act_ready    = r_act_ready;
    assign bus.turn         = r_turn;
    assign bus.call_amt     = r_call_amt;
    assign bus.min_raise_to = r_min_raise;
    assign bus.stack_out    = r_stack;
    assign bus.pot          = r_pot;
    assign bus.folded_out   = r_folded;
    assign bus.illegal      = r_illegal;
    assign bus.round_done   = r_round_done;
    assign bus.hand_over    = r_hand_over;
endmodule

// File: tb/tb_betting_round_ctrl.sv
// Directed bench for betting_round_ctrl on a 3-seat table; expectations are queued with
// each stimulus step and compared once the controller asks for the next action or finishes.
module tb_betting_round_ctrl;
    localparam int unsigned NP = 3;
    localparam int unsigned W  = 11;

    localparam int O_TURN  = 0;
    localparam int O_CALL  = 1;
    localparam int O_MINR  = 2;
    localparam int O_POT   = 3;
    localparam int O_DONE  = 4;
    localparam int O_HOVER = 5;
    localparam int O_ILL   = 6;
    localparam int O_RDY   = 7;
    localparam int O_FOLD  = 8;
    localparam int O_STK0  = 9;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    betting_round_ctrl_if #(.NUM_PLAYERS(NP), .STACK_W(W)) bus ();

    betting_round_ctrl #(
        .NUM_PLAYERS(NP),
        .STACK_W    (W),
        .SB_SIZE    (1),
        .BB_SIZE    (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            O_TURN:  return 32'(bus.turn);
            O_CALL:  return 32'(bus.call_amt);
            O_MINR:  return 32'(bus.min_raise_to);
            O_POT:   return 32'(bus.pot);
            O_DONE:  return 32'(bus.round_done);
            O_HOVER: return 32'(bus.hand_over);
            O_ILL:   return 32'(bus.illegal);
            O_RDY:   return 32'(bus.act_ready);
            O_FOLD:  return 32'(bus.folded_out);
            default: return 32'(bus.stack_out[(sel-O_STK0)*W +: W]);
        endcase
    endfunction

    task automatic expect_q(input string tag, input int sel, input logic [31:0] v);
        sb.push_back('{tag: tag, sel: sel, val: v});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
            end
        end
    endtask

    task automatic expect_all_zero(input string tag);
        expect_q({tag, "_turn"}, O_TURN, 0);
        expect_q({tag, "_call"}, O_CALL, 0);
        expect_q({tag, "_minr"}, O_MINR, 0);
        expect_q({tag, "_pot"}, O_POT, 0);
        expect_q({tag, "_done"}, O_DONE, 0);
        expect_q({tag, "_hover"}, O_HOVER, 0);
        expect_q({tag, "_ill"}, O_ILL, 0);
        expect_q({tag, "_rdy"}, O_RDY, 0);
        expect_q({tag, "_fold"}, O_FOLD, 0);
        for (int i = 0; i < NP; i++) expect_q($sformatf("%s_stk%0d", tag, i), O_STK0 + i, 0);
    endtask

    task automatic do_start(input logic pf, input logic [2:0] btn, input logic [W-1:0] s0,
                            input logic [W-1:0] s1, input logic [W-1:0] s2,
                            input logic [W-1:0] p, input logic [NP-1:0] f);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.preflop   = pf;
        bus.button    = btn;
        bus.stack_in  = {s2, s1, s0};
        bus.pot_in    = p;
        bus.folded_in = f;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic act(input logic [1:0] t, input logic [W-1:0] amt);
        @(negedge clk);
        bus.act_valid  = 1'b1;
        bus.act_type   = t;
        bus.act_amount = amt;
        @(posedge clk);
        #1 bus.act_valid = 1'b0;
    endtask

    // Bounded wait for the next decision point, then compare everything queued so far
    task automatic settle(input string tag);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.act_ready || bus.round_done) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s_timeout observed=0 expected=1", tag);
        end
        drain();
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.preflop    = 1'b0;
        bus.button     = '0;
        bus.stack_in   = '0;
        bus.pot_in     = '0;
        bus.folded_in  = '0;
        bus.act_valid  = 1'b0;
        bus.act_type   = '0;
        bus.act_amount = '0;
        repeat (3) @(negedge clk);
        expect_all_zero("rst");
        drain();
        reset = 1'b0;
        @(negedge clk);
        expect_all_zero("post_rst");
        drain();

        // 3 seats preflop: blinds on seats 1/2, seat 0 first to act
        do_start(1'b1, 3'd0, 11'd100, 11'd100, 11'd100, 11'd0, 3'b000);
        expect_q("pf_turn", O_TURN, 0);
        expect_q("pf_call", O_CALL, 2);
        expect_q("pf_minr", O_MINR, 4);
        expect_q("pf_pot", O_POT, 3);
        expect_q("pf_stk0", O_STK0 + 0, 100);
        expect_q("pf_stk1", O_STK0 + 1, 99);
        expect_q("pf_stk2", O_STK0 + 2, 98);
        expect_q("pf_rdy", O_RDY, 1);
        settle("pf");

        act(2'b01, 11'd3);
        expect_q("r3_ill", O_ILL, 1);
        expect_q("r3_turn", O_TURN, 0);
        expect_q("r3_call", O_CALL, 2);
        expect_q("r3_pot", O_POT, 3);
        expect_q("r3_stk0", O_STK0 + 0, 100);
        settle("r3");

        act(2'b01, 11'd6);
        expect_q("r6_ill", O_ILL, 0);
        expect_q("r6_turn", O_TURN, 1);
        expect_q("r6_call", O_CALL, 5);
        expect_q("r6_minr", O_MINR, 10);
        expect_q("r6_pot", O_POT, 9);
        expect_q("r6_stk0", O_STK0 + 0, 94);
        settle("r6");

        act(2'b00, 11'd0);
        expect_q("c1_turn", O_TURN, 2);
        expect_q("c1_call", O_CALL, 4);
        expect_q("c1_pot", O_POT, 14);
        settle("c1");

        act(2'b00, 11'd0);
        expect_q("c2_done", O_DONE, 1);
        expect_q("c2_hover", O_HOVER, 0);
        expect_q("c2_pot", O_POT, 18);
        expect_q("c2_stk2", O_STK0 + 2, 94);
        expect_q("c2_rdy", O_RDY, 0);
        settle("c2");

        // Heads-up postflop (seat 2 folded in): check, check
        do_start(1'b0, 3'd0, 11'd100, 11'd100, 11'd100, 11'd50, 3'b100);
        expect_q("hu_turn", O_TURN, 1);
        expect_q("hu_call", O_CALL, 0);
        expect_q("hu_minr", O_MINR, 2);
        expect_q("hu_done", O_DONE, 0);
        settle("hu");
        act(2'b00, 11'd0);
        expect_q("hu_ck1_turn", O_TURN, 0);
        settle("hu_ck1");
        act(2'b00, 11'd0);
        expect_q("hu_ck2_done", O_DONE, 1);
        expect_q("hu_ck2_hover", O_HOVER, 0);
        expect_q("hu_ck2_pot", O_POT, 50);
        settle("hu_ck2");

        // Heads-up postflop: fold ends the hand
        do_start(1'b0, 3'd0, 11'd100, 11'd100, 11'd100, 11'd50, 3'b100);
        expect_q("hf_turn", O_TURN, 1);
        settle("hf");
        act(2'b10, 11'd0);
        expect_q("hf_done", O_DONE, 1);
        expect_q("hf_hover", O_HOVER, 1);
        expect_q("hf_fold", O_FOLD, 3'b110);
        expect_q("hf_pot", O_POT, 50);
        settle("hf_fold");

        // Heads-up preflop, SB seat 1 holds one chip: all-in on the blind, done after BB
        do_start(1'b1, 3'd0, 11'd100, 11'd1, 11'd100, 11'd0, 3'b100);
        expect_q("sbai_done", O_DONE, 1);
        expect_q("sbai_hover", O_HOVER, 0);
        expect_q("sbai_pot", O_POT, 3);
        expect_q("sbai_stk1", O_STK0 + 1, 0);
        expect_q("sbai_stk0", O_STK0 + 0, 98);
        expect_q("sbai_rdy", O_RDY, 0);
        settle("sbai");

        // Short all-in: seat 1 bets 10, seat 2 shoves 12, raise increment stays 10
        do_start(1'b0, 3'd0, 11'd100, 11'd100, 11'd12, 11'd0, 3'b000);
        expect_q("sa_turn", O_TURN, 1);
        settle("sa");
        act(2'b01, 11'd10);
        expect_q("sa_b_turn", O_TURN, 2);
        expect_q("sa_b_call", O_CALL, 10);
        expect_q("sa_b_minr", O_MINR, 20);
        settle("sa_b");
        act(2'b01, 11'd12);
        expect_q("sa_s_ill", O_ILL, 0);
        expect_q("sa_s_turn", O_TURN, 0);
        expect_q("sa_s_call", O_CALL, 12);
        expect_q("sa_s_minr", O_MINR, 22);
        expect_q("sa_s_stk2", O_STK0 + 2, 0);
        settle("sa_s");
        act(2'b00, 11'd0);
        expect_q("sa_c_turn", O_TURN, 1);
        expect_q("sa_c_call", O_CALL, 2);
        expect_q("sa_c_minr", O_MINR, 22);
        expect_q("sa_c_done", O_DONE, 0);
        settle("sa_c");
        act(2'b00, 11'd0);
        expect_q("sa_e_done", O_DONE, 1);
        expect_q("sa_e_pot", O_POT, 36);
        settle("sa_e");

        // Reset while an accepted action sits in APPLY
        do_start(1'b1, 3'd0, 11'd100, 11'd100, 11'd100, 11'd0, 3'b000);
        expect_q("ra_turn", O_TURN, 0);
        settle("ra");
        @(negedge clk);
        bus.act_valid = 1'b1;
        bus.act_type  = 2'b00;
        @(posedge clk);
        #1;
        bus.act_valid = 1'b0;
        reset = 1'b1;
        #1;
        expect_all_zero("ra_rst");
        drain();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_all_zero("ra_idle");
        drain();

        do_start(1'b0, 3'd0, 11'd40, 11'd40, 11'd40, 11'd0, 3'b000);
        expect_q("rec_turn", O_TURN, 1);
        expect_q("rec_stk1", O_STK0 + 1, 40);
        settle("rec");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
